sram_frame_reader: RTL and testbench

- Read-side client of the SRAM arbiter. Streams one frame out of SRAM and hands it to the feature-detection pipeline as a pixel stream.
- Issues sequential word addresses on an arbiter read port (r0/r1 request/response handshake).
- Buffers returned words, bounded by a credit counter, and unpacks each word into pixels with backpressure.

---
 rtl/sram_frame_reader.sv | 210 +++++++++++++++++++++
 tb/tb_sram_frame_reader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_frame_reader.sv
// Reads one frame of sequential SRAM words through an arbiter read port and unpacks them into a pixel stream.
// Define SRAM_FRAME_READER_CHECKSUM_EN to add a checksum output (XOR of every word unpacked in the frame).
module sram_frame_reader #(
    parameter int ADDR_WIDTH      = 18,
    parameter int DATA_WIDTH      = 32,
    parameter int PIXEL_WIDTH     = 8,
    parameter int FRAME_WORDS     = 76800,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    output logic                   busy,
    output logic                   done,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic                   resp_valid,
    output logic                   resp_ready,
    input  logic [DATA_WIDTH-1:0]  resp_data,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic [PIXEL_WIDTH-1:0] pix_data,
    output logic                   pix_last
`ifdef SRAM_FRAME_READER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]  checksum
`endif
);
    localparam int PPW    = DATA_WIDTH / PIXEL_WIDTH;
    localparam int IDX_W  = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int WCNT_W = $clog2(FRAME_WORDS + 1);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(FRAME_WORDS - 1);
    localparam logic [WCNT_W-1:0] ALL_WORDS = WCNT_W'(FRAME_WORDS);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PPW - 1);
    localparam logic              ONE_PIX   = (PPW == 1) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t                  state_r;
    logic                    busy_r, done_r, req_valid_r, resp_ready_r;
    logic                    pix_valid_r, pix_last_r, word_last_r;
    logic [ADDR_WIDTH-1:0]   req_addr_r;
    logic [WCNT_W-1:0]       issued_r, popped_r;
    logic [CNT_W-1:0]        credits_r, fifo_cnt_r;
    logic [PTR_W-1:0]        wr_ptr_r, rd_ptr_r;
    logic [DATA_WIDTH-1:0]   fifo_mem_r [MAX_OUTSTANDING];
    logic [DATA_WIDTH-1:0]   hold_r;
    logic [IDX_W-1:0]        idx_r;

    logic                    req_fire_s, push_s, pop_s, pix_fire_s, word_end_s, frame_end_s, accept_s;
    logic [CNT_W-1:0]        credits_nxt_s, fifo_cnt_nxt_s;
    logic [WCNT_W-1:0]       issued_nxt_s;

    // Handshake decode and next values of the credit, FIFO and issue counters
    always_comb begin
        accept_s    = (state_r == IDLE) && start;
        req_fire_s  = req_valid_r && req_ready;
        push_s      = resp_valid && resp_ready_r && ((state_r == FETCH) || (state_r == DRAIN));
        pix_fire_s  = pix_valid_r && pix_ready;
        word_end_s  = pix_fire_s && (idx_r == LAST_IDX);
        frame_end_s = pix_fire_s && pix_last_r;
        // Refill the holding register when empty or as its last pixel leaves, so words stream back to back
        pop_s       = (fifo_cnt_r != '0) && (!pix_valid_r || word_end_s);
        issued_nxt_s = issued_r + {{(WCNT_W-1){1'b0}}, req_fire_s};
        if (req_fire_s && !pop_s) begin
            credits_nxt_s = credits_r - CNT_W'(1);
        end else if (pop_s && !req_fire_s) begin
            credits_nxt_s = credits_r + CNT_W'(1);
        end else begin
            credits_nxt_s = credits_r;
        end
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_nxt_s = fifo_cnt_r + CNT_W'(1);
            2'b01:   fifo_cnt_nxt_s = fifo_cnt_r - CNT_W'(1);
            default: fifo_cnt_nxt_s = fifo_cnt_r;
        endcase
    end

    // Frame control FSM: request issue, credit accounting, busy/done
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            req_valid_r <= 1'b0;
            req_addr_r  <= '0;
            issued_r    <= '0;
            credits_r   <= FULL_CNT;
        end else begin
            credits_r <= credits_nxt_s;
            done_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r     <= FETCH;
                        busy_r      <= 1'b1;
                        req_valid_r <= 1'b1;
                        req_addr_r  <= base_addr;
                        issued_r    <= '0;
                    end
                end
                FETCH: begin
                    if (req_fire_s) begin
                        req_addr_r <= req_addr_r + ADDR_WIDTH'(1);
                    end
                    issued_r    <= issued_nxt_s;
                    req_valid_r <= (issued_nxt_s != ALL_WORDS) && (credits_nxt_s != '0);
                    if (issued_nxt_s == ALL_WORDS) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (frame_end_s) begin
                        state_r <= FINISH;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                FINISH:  state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Response buffer storage (data only, occupancy is tracked separately)
    always_ff @(posedge clock) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= resp_data;
        end
    end

    // Response buffer pointers and the word-to-pixel unpacker
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            fifo_cnt_r   <= '0;
            resp_ready_r <= 1'b1;
            pix_valid_r  <= 1'b0;
            pix_last_r   <= 1'b0;
            word_last_r  <= 1'b0;
            hold_r       <= '0;
            idx_r        <= '0;
            popped_r     <= '0;
        end else begin
            fifo_cnt_r   <= fifo_cnt_nxt_s;
            resp_ready_r <= (fifo_cnt_nxt_s != FULL_CNT);
            if (push_s) begin
                wr_ptr_r <= (wr_ptr_r == LAST_PTR) ? '0 : wr_ptr_r + PTR_W'(1);
            end
            if (accept_s) begin
                popped_r <= '0;
            end else if (pop_s) begin
                popped_r <= popped_r + WCNT_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r    <= (rd_ptr_r == LAST_PTR) ? '0 : rd_ptr_r + PTR_W'(1);
                hold_r      <= fifo_mem_r[rd_ptr_r];
                idx_r       <= '0;
                pix_valid_r <= 1'b1;
                word_last_r <= (popped_r == LAST_WORD);
                pix_last_r  <= (popped_r == LAST_WORD) && ONE_PIX;
            end else if (word_end_s) begin
                pix_valid_r <= 1'b0;
                pix_last_r  <= 1'b0;
            end else if (pix_fire_s) begin
                hold_r     <= hold_r >> PIXEL_WIDTH;
                idx_r      <= idx_r + IDX_W'(1);
                pix_last_r <= word_last_r && ((idx_r + IDX_W'(1)) == LAST_IDX);
            end
        end
    end

`ifdef SRAM_FRAME_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_r;

    // Running XOR of every word handed to the unpacker during the frame
    always_ff @(posedge clock) begin
        if (reset) begin
            checksum_r <= '0;
        end else if (accept_s) begin
            checksum_r <= '0;
        end else if (pop_s) begin
            checksum_r <= checksum_r ^ fifo_mem_r[rd_ptr_r];
        end
    end

    assign checksum = checksum_r;
`endif

    assign busy       = busy_r;
    assign done       = done_r;
    assign req_valid  = req_valid_r;
    assign req_addr   = req_addr_r;
    assign resp_ready = resp_ready_r;
    assign pix_valid  = pix_valid_r;
    assign pix_data   = hold_r[PIXEL_WIDTH-1:0];
    assign pix_last   = pix_last_r;
endmodule

// File: tb/tb_sram_frame_reader.sv
// Bench for sram_frame_reader: table of frame scenarios against an arbiter/SRAM model and an expected pixel list.
module tb_sram_frame_reader;
    localparam int AW  = 18;
    localparam int DW  = 32;
    localparam int PW  = 8;
    localparam int FW  = 8;
    localparam int MO  = 4;
    localparam int PPW = DW / PW;

    logic          clock = 1'b0;
    logic          reset, start, req_ready, resp_valid, pix_ready;
    logic [AW-1:0] base_addr, req_addr;
    logic [DW-1:0] resp_data;
    logic          busy, done, req_valid, resp_ready, pix_valid, pix_last;
    logic [PW-1:0] pix_data;
`ifdef SRAM_FRAME_READER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    sram_frame_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIXEL_WIDTH(PW),
        .FRAME_WORDS(FW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_last(pix_last)
`ifdef SRAM_FRAME_READER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] base;
        int            lat;
        int            pmode;     // 0: always ready, 1: toggle, 2: random
        int            rmode;     // 0: req_ready always 1, 1: random
        int            hold;      // cycles after start before any response is returned
        bit            mid;       // pulse start mid-frame
        bit            fin;       // pulse start while done is high
        bit            chk_lat;
        logic [AW-1:0] exp_last;
    } vec_t;

    vec_t          vecs[6];
    int            checks = 0, errors = 0, cyc = 0;
    logic [AW-1:0] exp_addr_q[$];
    logic [PW:0]   exp_pix_q[$];
    logic [DW-1:0] rsp_data_q[$];
    int            rsp_time_q[$];
    int            hold_until, req_cnt, resp_cnt, done_cnt, start_cyc, first_pix_cyc;
    int            lat, pmode, rmode;
    bit            mid_start, fin_start, chk_lat, prev_stall;
    logic [PW-1:0] prev_data;
    logic [AW-1:0] last_addr, cur_base;
    logic [DW-1:0] exp_sum;

    // SRAM contents: word at 0x100+n is 0x03020100 + 0x04040404*n
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [AW-1:0] off;
        off = a - 18'h00100;
        return 32'h03020100 + 32'h04040404 * DW'(off);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; pix_ready = 1'b0;
        @(negedge clock);
        cyc++;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_req_addr", req_addr, 0);
        chk("rst_resp_ready", resp_ready, 1);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_last", pix_last, 0);
`ifdef SRAM_FRAME_READER_CHECKSUM_EN
        chk("rst_checksum", checksum, 0);
`endif
        reset = 1'b0;
        exp_addr_q.delete(); exp_pix_q.delete(); rsp_data_q.delete(); rsp_time_q.delete();
        mid_start = 1'b0; fin_start = 1'b0; hold_until = 0; prev_stall = 1'b0;
    endtask

    task automatic begin_frame(input vec_t v);
        logic [AW-1:0] a;
        logic [DW-1:0] w;
        exp_addr_q.delete(); exp_pix_q.delete();
        exp_sum = '0;
        for (int n = 0; n < FW; n++) begin
            a = v.base + AW'(n);
            exp_addr_q.push_back(a);
            w = mem_word(a);
            exp_sum ^= w;
            for (int k = 0; k < PPW; k++) begin
                exp_pix_q.push_back({(n == FW-1) && (k == PPW-1), w[k*PW +: PW]});
            end
        end
        cur_base = v.base; lat = v.lat; pmode = v.pmode; rmode = v.rmode;
        mid_start = v.mid; fin_start = v.fin; chk_lat = v.chk_lat;
        start_cyc = cyc + 1; hold_until = start_cyc + v.hold;
        req_cnt = 0; resp_cnt = 0; done_cnt = 0; first_pix_cyc = -1; prev_stall = 1'b0; last_addr = 'x;
    endtask

    // One clock of stimulus and observation; DUT outputs are registered so handshakes are decided here
    task automatic step(input bit do_start);
        logic [PW:0] e;
        @(negedge clock);
        cyc++;
        start     = do_start || (mid_start && (cyc == start_cyc + 6)) || (fin_start && done);
        base_addr = do_start ? cur_base : AW'($urandom);
        req_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        case (pmode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = cyc[0];
            default: pix_ready = 1'($urandom_range(0, 1));
        endcase
        if (rsp_data_q.size() > 0 && rsp_time_q[0] <= cyc && cyc >= hold_until) begin
            resp_valid = 1'b1; resp_data = rsp_data_q[0];
        end else begin
            resp_valid = 1'b0; resp_data = DW'($urandom);
        end
        if (do_start) chk("idle_before_start", busy, 0);
        if (cyc == start_cyc + 1) begin
            chk("busy_after_start", busy, 1);
            chk("req_valid_after_start", req_valid, 1);
        end
        if (hold_until > start_cyc + 1 && cyc == hold_until - 1) begin
            chk("credit_limited_reqs", req_cnt, MO);
            chk("req_valid_no_credit", req_valid, 0);
        end
        chk("resp_not_dropped", resp_valid && !resp_ready, 0);
        if (req_valid && req_ready) begin
            if (exp_addr_q.size() == 0) begin
                chk("extra_req", exp_addr_q.size(), 1);
            end else begin
                chk("req_addr", req_addr, exp_addr_q.pop_front());
            end
            rsp_data_q.push_back(mem_word(req_addr));
            rsp_time_q.push_back(cyc + lat);
            last_addr = req_addr;
            req_cnt++;
        end
        if (resp_valid && resp_ready) begin
            void'(rsp_data_q.pop_front());
            void'(rsp_time_q.pop_front());
            resp_cnt++;
        end
        chk("outstanding_le_max", (req_cnt - resp_cnt) <= MO, 1);
        if (prev_stall) begin
            chk("stall_valid_held", pix_valid, 1);
            chk("stall_data_held", pix_data, prev_data);
        end
        if (pix_valid && first_pix_cyc < 0) begin
            first_pix_cyc = cyc;
            if (chk_lat) chk("first_pix_latency", cyc - start_cyc, lat + 3);
        end
        if (pix_valid && pix_ready) begin
            if (exp_pix_q.size() == 0) begin
                chk("extra_pixel", exp_pix_q.size(), 1);
            end else begin
                e = exp_pix_q.pop_front();
                chk("pix_data", pix_data, e[PW-1:0]);
                chk("pix_last", pix_last, e[PW]);
            end
        end
        prev_stall = pix_valid && !pix_ready;
        prev_data  = pix_data;
        if (done) begin
            done_cnt++;
            chk("busy_low_at_done", busy, 0);
            chk("pixels_left_at_done", exp_pix_q.size(), 0);
        end
    endtask

    task automatic run_frame(input vec_t v);
        int n;
        begin_frame(v);
        step(1'b1);
        n = 0;
        while (done_cnt == 0 && n < 600) begin
            step(1'b0);
            n++;
        end
        if (done_cnt == 0) chk("done_timeout", done_cnt, 1);
        repeat (3) step(1'b0);
        chk("done_pulses", done_cnt, 1);
        chk("busy_after_done", busy, 0);
        chk("req_valid_after_done", req_valid, 0);
        chk("last_req_addr", last_addr, v.exp_last);
        chk("addrs_left", exp_addr_q.size(), 0);
`ifdef SRAM_FRAME_READER_CHECKSUM_EN
        chk("checksum_held", checksum, exp_sum);
`endif
    endtask

    initial begin
        logic [AW-1:0] rb;
        vec_t          rv;
        reset = 1'b1; start = 1'b0; base_addr = '0; req_ready = 1'b0;
        resp_valid = 1'b0; resp_data = '0; pix_ready = 1'b0;
        lat = 2; pmode = 0; rmode = 0; mid_start = 1'b0; fin_start = 1'b0; chk_lat = 1'b0;
        start_cyc = 0; hold_until = 0; cur_base = '0;
        rb = AW'($urandom);
        vecs[0] = '{18'h00100, 2, 0, 0, 0,  1'b0, 1'b1, 1'b1, 18'h00107};
        vecs[1] = '{18'h00100, 2, 1, 0, 0,  1'b0, 1'b0, 1'b0, 18'h00107};
        vecs[2] = '{18'h00200, 3, 0, 0, 20, 1'b0, 1'b0, 1'b0, 18'h00207};
        vecs[3] = '{18'h3FFFE, 2, 0, 0, 0,  1'b0, 1'b0, 1'b0, 18'h00005};
        vecs[4] = '{18'h01234, 1, 2, 1, 0,  1'b1, 1'b0, 1'b0, 18'h0123B};
        vecs[5] = '{rb,        4, 2, 1, 0,  1'b1, 1'b1, 1'b0, rb + 18'd7};

        repeat (2) @(negedge clock);
        do_reset();
        for (int i = 0; i < 4; i++) run_frame(vecs[i]);

        // Abort a frame in FETCH, then a fresh frame must complete cleanly
        begin_frame(vecs[0]);
        step(1'b1);
        repeat (3) step(1'b0);
        do_reset();
        run_frame(vecs[0]);

        for (int i = 4; i < 6; i++) run_frame(vecs[i]);
        for (int r = 0; r < 4; r++) begin
            rv = '{AW'($urandom), $urandom_range(1, 5), $urandom_range(0, 2), $urandom_range(0, 1),
                   0, 1'b1, 1'b1, 1'b0, 'x};
            rv.exp_last = rv.base + 18'd7;
            run_frame(rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
